axi_wr_slave_mem: RTL
=====================

Name: axi_wr_slave_mem

Overview:
AXI4 write-channel slave backed by an internal word-addressed RAM. It accepts an AW burst, absorbs the W beats with byte strobes, and returns one B response per burst. It is the responder end of the DMA write master and serves as the write target in interconnect and DMA testbenches. A registered debug read port exposes RAM contents for checking.

Parameters:
AXI_DATA_WIDTH, 32, W data width in bits (power of 2, >=8)
AXI_ADDR_WIDTH, 32, byte address width
AXI_ID_WIDTH, 8, AW/B ID width
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte strobe width
MEM_DEPTH, 1024, RAM depth in words (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axi_awid  in  AXI_ID_WIDTH  burst ID
s_axi_awaddr  in  AXI_ADDR_WIDTH  start byte address
s_axi_awlen  in  8  beats minus one
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_STRB_WIDTH  byte enables
s_axi_wlast  in  1  last beat flag
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  AXI_ID_WIDTH  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
dbg_addr  in  log2(MEM_DEPTH)  debug word index
dbg_rdata  out  AXI_DATA_WIDTH  debug read data, one-cycle latency

Behaviour:
- Reset (async, rst_n low): state IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=00, dbg_rdata=0. RAM contents are not reset. awready rises the first clk edge after rst_n deasserts.
- Reset mid-burst: burst abandoned, no B issued. Beats already written remain in RAM.
- ADDR_LSB = log2(AXI_STRB_WIDTH). Start address is aligned down, so low ADDR_LSB bits are ignored. Word index = addr >> ADDR_LSB.
- FSM IDLE: awready=1, wready=0. On awvalid&awready, latch id/addr/len/size/burst, clear beat counter and error flags, then go to DATA. Next cycle awready=0 and wready=1.
- AW check at capture: awsize != ADDR_LSB, or awburst==11, or WRAP without the feature, sets err_slv.
- FSM DATA: wready=1, one beat per cycle.
  - On each wvalid&wready, write bytes with wstrb=1 to RAM[word index] unless err_slv is set or the index >= MEM_DEPTH. An out-of-range index sets err_dec and the beat is dropped.
  - Address update: INCR adds 2^ADDR_LSB modulo 2^AXI_ADDR_WIDTH. FIXED keeps the address.
  - Burst ends on the beat where counter==awlen, independent of wlast. wlast asserted on any other beat, or deasserted on the final beat, sets err_slv; beats keep counting.
  - After the final beat go to RESP. wready=0 the next cycle.
- FSM RESP: bvalid=1, bid=latched id. bresp = 11 if err_dec, else 10 if err_slv, else 00. bid/bresp are held stable until bready. On bvalid&bready go to IDLE; bvalid=0 and awready=1 the next cycle.
- Latency: bvalid is asserted the cycle after the final W handshake. Only one burst is outstanding; no AW is accepted in DATA or RESP.
- awlen=0: single beat, same flow.
- Debug port: dbg_rdata <= RAM[dbg_addr] every cycle. A read of a word written in the same cycle returns the old data.

Optional Feature:
AXI_WR_SLV_WRAP_EN
- Defined: WRAP bursts are supported.
  - awlen must be 1, 3, 7 or 15, otherwise err_slv is set.
  - Wrap boundary = (awlen+1)*2^ADDR_LSB bytes. The address increments and wraps to the aligned boundary base.
- Undefined: awburst==10 sets err_slv. All beats are accepted and discarded, and B returns SLVERR.

Test Plan:
- INCR write: addr 0x100, len 3, size 2, data 0xA0..0xA3, strb F, wlast on beat 3 -> words 0x40..0x43 hold A0..A3; B id matches awid, bresp 00, bvalid one cycle after the last beat.
- Strobes: preload 0xFFFFFFFF at word 5, single beat at addr 0x14 with data 0x12345678, strb 0101 -> dbg_rdata = 0xFF34FF78.
- FIXED burst: len 2 to addr 0x20, data 1,2,3 -> word 8 = 3, bresp 00.
- Errors:
  - addr = MEM_DEPTH*4, len 0 -> no write, bresp 11.
  - wlast on beat 1 of a len 3 burst -> all 4 beats accepted, bresp 10.
  - awsize=1 -> no writes, bresp 10.
- Backpressure: bready held low 5 cycles -> bvalid/bid/bresp stable, awready=0 until 1 cycle after the B handshake. wvalid gaps -> beat count unaffected.
- WRAP: with the macro, addr 0x38, len 3 -> words 0x0E, 0x0F, 0x0C, 0x0D written, bresp 00. Without the macro -> no writes, bresp 10. Separately, rst_n pulse mid-burst -> IDLE, no B, awready=1 after release.

Source files
------------

// File: rtl/axi_wr_slave_mem.sv
// ============================================================================
// axi_wr_slave_mem
// ----------------------------------------------------------------------------
// AXI4 write-channel slave backed by an internal word-addressed RAM. Accepts
// one AW burst at a time, absorbs its W beats with byte strobes, and returns
// a single B response per burst. A registered debug port reads RAM contents.
//
// Optional feature macro: AXI_WR_SLV_WRAP_EN
//   defined   : WRAP bursts (awlen 1/3/7/15) are written with wrapping address
//   undefined : WRAP bursts are absorbed without writing and answered SLVERR
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axi_aw*           write address channel (id, addr, len, size, burst)
//   s_axi_w*            write data channel (data, strb, last)
//   s_axi_b*            write response channel (id, resp)
//   dbg_addr            debug word index
//   dbg_rdata           RAM[dbg_addr], one cycle latency
// ============================================================================
module axi_wr_slave_mem #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]     s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
  output logic [AXI_DATA_WIDTH-1:0]     dbg_rdata
);

  localparam int ADDR_LSB = $clog2(AXI_STRB_WIDTH);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  localparam logic [AXI_ADDR_WIDTH-1:0] STEP       = AXI_ADDR_WIDTH'(AXI_STRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A    = AXI_ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // ST_RST holds awready low for the first edge after reset release.
  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_DATA, ST_RESP} state_t;

  state_t state_q, state_d;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]                len_q;
  logic [1:0]                burst_q;
  logic [7:0]                beat_q;
  logic                      err_slv_q;
  logic                      err_dec_q;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                      aw_hs;
  logic                      w_hs;
  logic                      last_beat;
  logic                      in_range;
  logic                      wr_en;
  logic [IDX_W-1:0]          mem_idx;

  // Burst-level protocol check applied to the AW request at capture.
  function automatic logic aw_check_err(input logic [2:0] size,
                                        input logic [1:0] burst,
                                        input logic [7:0] len);
    logic err;
    err = (size != 3'(ADDR_LSB)) || (burst == BURST_RSVD);
`ifdef AXI_WR_SLV_WRAP_EN
    if ((burst == BURST_WRAP) &&
        !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)))
      err = 1'b1;
`else
    if (burst == BURST_WRAP)
      err = 1'b1;
    if (len == 8'hxx)
      err = err;
`endif
    return err;
  endfunction

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign last_beat = (beat_q == len_q);
  assign in_range  = (addr_q >> ADDR_LSB) < DEPTH_A;
  assign mem_idx   = addr_q[ADDR_LSB +: IDX_W];
  assign wr_en     = w_hs & in_range & ~err_slv_q;

  // Address for the beat after the current one.
`ifdef AXI_WR_SLV_WRAP_EN
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  // Wrap window is (len+1) beats; len is restricted to 1/3/7/15 so this is a
  // power-of-two byte span aligned to its own size.
  assign wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + 1'b1) << ADDR_LSB) - 1'b1;
`endif

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BURST_INCR:  addr_nxt = addr_q + STEP;
`ifdef AXI_WR_SLV_WRAP_EN
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + STEP) & wrap_mask);
`endif
      BURST_FIXED: addr_nxt = addr_q;
      default:     addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_IDLE;
      ST_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    s_axi_bresp = 2'b00;
    if (state_q == ST_RESP) begin
      if (err_dec_q)      s_axi_bresp = 2'b11;
      else if (err_slv_q) s_axi_bresp = 2'b10;
    end
  end

  assign s_axi_bid = id_q;

  // Control: state, beat count, error flags, response ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      id_q      <= '0;
      beat_q    <= '0;
      err_slv_q <= 1'b0;
      err_dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q      <= s_axi_awid;
        beat_q    <= '0;
        err_slv_q <= aw_check_err(s_axi_awsize, s_axi_awburst, s_axi_awlen);
        err_dec_q <= 1'b0;
      end else if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        // Counter, not wlast, terminates the burst; a mismatch only flags it.
        if (s_axi_wlast != last_beat) err_slv_q <= 1'b1;
        if (!in_range)                err_dec_q <= 1'b1;
      end
    end
  end

  // Burst address tracking (data path, no reset)
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      addr_q  <= s_axi_awaddr & ALIGN_MASK;
      len_q   <= s_axi_awlen;
      burst_q <= s_axi_awburst;
    end else if (w_hs) begin
      addr_q <= addr_nxt;
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
      if (wr_en && s_axi_wstrb[b])
        mem[mem_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // Debug read port: read-before-write on a same-cycle collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_rdata <= '0;
    else        dbg_rdata <= mem[dbg_addr];
  end

endmodule
